execute_mult_unit: RTL

- Iterative shift-add integer multiplier inside the execute stage.
- Consumes the multiply controls and register operands latched by the decode-to-execute pipeline register: mult, mult_half, mult_signed_a, mult_signed_b, rdat1 and rdat2.
- Stalls the pipeline until the product is ready, then presents the selected 32-bit half to the execute-stage writeback mux.
- Covers MUL, MULH, MULHSU and MULHU.

---
 rtl/common_types_pkg.sv | 16 +
 rtl/execute_mult_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/common_types_pkg.sv
// Shared execute-stage types and small helpers.
package common_types_pkg;

   // Sequencer states of the iterative multiplier
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      FINISH = 2'd2
   } mult_state_t;

   // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned 2^31
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/execute_mult_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU in the execute stage.
// Multiplies operand magnitudes, then applies the sign to the 64-bit product.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; captures magnitudes, sign and half select
// BUSY   | retires BITS_PER_CYCLE multiplier bits per cycle for ITERS cycles
// FINISH | done pulse; result stable; always returns to IDLE
module execute_mult_unit
   import common_types_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic        mult_half,
   input  logic        signed_a,
   input  logic        signed_b,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall,
   output logic        done,
   output logic [31:0] result
);

   localparam int ITERS = 32 / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(ITERS);
   localparam int SUM_W = 32 + BITS_PER_CYCLE;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   mult_state_t                state;
   logic [CNT_W-1:0]           cnt;
   logic [63:0]                acc;
   logic [31:0]                mcand;
   logic [31:0]                mplier;
   logic                       neg;
   logic                       half_q;
   logic [31:0]                result_q;
   logic                       done_q;

   logic [BITS_PER_CYCLE-1:0]  digit;
   logic [SUM_W-1:0]           pp;
   logic [SUM_W-1:0]           sum;
   logic [63:0]                acc_next;
   logic [63:0]                prod;
   logic [31:0]                half_sel;

   // One iteration: add |a| * digit into the upper half, then shift the whole accumulator right
   always_comb begin
      digit    = mplier[BITS_PER_CYCLE-1:0];
      pp       = {{BITS_PER_CYCLE{1'b0}}, mcand} * {{32{1'b0}}, digit};
      sum      = {{BITS_PER_CYCLE{1'b0}}, acc[63:32]} + pp;
      acc_next = {sum, acc[31:BITS_PER_CYCLE]};
      prod     = neg ? (~acc_next + 64'd1) : acc_next;
      half_sel = half_q ? prod[63:32] : prod[31:0];
   end

   // Hold the pipeline while a multiply is pending; never in FINISH, never during a flush
   always_comb begin
      stall = start & ~flush & (state != FINISH);
   end

   assign done   = done_q;
   assign result = result_q;

   // Sequencer, datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         neg      <= 1'b0;
         half_q   <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mcand  <= mag32(a, signed_a);
                     mplier <= mag32(b, signed_b);
                     neg    <= (signed_a & a[31]) ^ (signed_b & b[31]);
                     half_q <= mult_half;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= BUSY;
                  end
               end
               BUSY: begin
                  acc    <= acc_next;
                  mplier <= mplier >> BITS_PER_CYCLE;
                  cnt    <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     result_q <= half_sel;
                     done_q   <= 1'b1;
                     state    <= FINISH;
                  end
               end
               FINISH: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
